// File: rtl/regfile_ctrl_pkg.sv
// Shared core types: register index and writeback source.
// Imported by the scoreboard, arbiter and bus interface.
package rvcpu;

    typedef logic [4:0] reg_t;

    typedef enum logic {
        WB_ALU = 1'b0,
        WB_LSU = 1'b1
    } wb_src_e;

    localparam int unsigned NumSrc = 2;

endpackage

// File: rtl/regfile_ctrl_if.sv
// Issue, writeback and regfile-port bundle around the scoreboard.
// master = decoder/exec units/regfile side, slave = regfile_ctrl.
interface regfile_ctrl_if #(
    parameter int Width   = 32,
    parameter int NumRegs = 32
);
    import rvcpu::*;

    localparam int CntW = $clog2(NumRegs);

    logic             issue_valid;
    logic             issue_ready;
    reg_t             issue_rs1;
    logic             issue_rs1_used;
    reg_t             issue_rs2;
    logic             issue_rs2_used;
    reg_t             issue_rd;
    logic             issue_rd_used;

    reg_t             rs1;
    logic             rs1_valid;
    reg_t             rs2;
    logic             rs2_valid;

    logic             wb0_valid;
    logic             wb0_ready;
    reg_t             wb0_rd;
    logic [Width-1:0] wb0_data;
    logic             wb1_valid;
    logic             wb1_ready;
    reg_t             wb1_rd;
    logic [Width-1:0] wb1_data;

    reg_t             rw;
    logic             we;
    logic [Width-1:0] wval;
    logic [CntW-1:0]  outstanding;

    modport slave (
        input  issue_valid, issue_rs1, issue_rs1_used,
        input  issue_rs2, issue_rs2_used,
        input  issue_rd, issue_rd_used,
        output issue_ready,
        output rs1, rs1_valid, rs2, rs2_valid,
        input  wb0_valid, wb0_rd, wb0_data,
        output wb0_ready,
        input  wb1_valid, wb1_rd, wb1_data,
        output wb1_ready,
        output rw, we, wval, outstanding
    );

    modport master (
        output issue_valid, issue_rs1, issue_rs1_used,
        output issue_rs2, issue_rs2_used,
        output issue_rd, issue_rd_used,
        input  issue_ready,
        input  rs1, rs1_valid, rs2, rs2_valid,
        output wb0_valid, wb0_rd, wb0_data,
        input  wb0_ready,
        output wb1_valid, wb1_rd, wb1_data,
        input  wb1_ready,
        input  rw, we, wval, outstanding
    );

endinterface

// File: rtl/regfile_ctrl_arbiter.sv
// Two-way round-robin arbiter for the ALU/LSU writeback sources.
// Holds rr_last; the source not granted last wins a tie.
module wb_rr_arbiter
    import rvcpu::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    wb_src_e rr_last;

    always_comb begin
        gnt    = 2'b00;
        gnt[0] = req[0] & (~req[1] | (rr_last == WB_LSU));
        gnt[1] = req[1] & (~req[0] | (rr_last == WB_ALU));
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rr_last <= WB_LSU;
        end else if (advance) begin
            rr_last <= gnt[1] ? WB_LSU : WB_ALU;
        end
    end

endmodule

// File: rtl/regfile_ctrl.sv
// Scoreboard and write-port scheduler in front of the 2R/1W regfile.
// Stalls issue on RAW/WAW and serialises ALU/LSU writebacks.
module regfile_ctrl
    import rvcpu::*;
#(
    parameter int Width   = 32,
    parameter int NumRegs = 32
) (
    input  logic           clk,
    input  logic           reset,
    regfile_ctrl_if.slave  bus
);

    localparam int CntW = $clog2(NumRegs);

    logic [NumRegs-1:1] busy_q;
    logic [NumRegs-1:0] busy;
    logic [CntW-1:0]    cnt_q;
    logic [CntW-1:0]    cnt_d;
    reg_t               rw_q;
    logic               we_q;
    logic [Width-1:0]   wval_q;

    logic               stall;
    logic               fire;
    logic               set_en;
    logic               clr_en;
    logic [1:0]         req;
    logic [1:0]         gnt;
    logic               grant;
    reg_t               sel_rd;
    logic [Width-1:0]   sel_data;

    assign busy = {busy_q, 1'b0};

    function automatic logic hit(
        input logic [NumRegs-1:0] vec,
        input reg_t               r
    );
        hit = 1'b0;
        for (int i = 0; i < NumRegs; i++) begin
            if (r == reg_t'(i)) hit = vec[i];
        end
    endfunction

    // No bypass: a register whose write sits in the write stage still stalls.
    always_comb begin
        stall = 1'b0;
        if (bus.issue_rs1_used && hit(busy, bus.issue_rs1)) stall = 1'b1;
        if (bus.issue_rs2_used && hit(busy, bus.issue_rs2)) stall = 1'b1;
        if (bus.issue_rd_used && hit(busy, bus.issue_rd)) stall = 1'b1;
    end

    assign bus.issue_ready = reset & bus.issue_valid & ~stall;
    assign fire   = bus.issue_valid & bus.issue_ready;
    assign set_en = fire & bus.issue_rd_used & (bus.issue_rd != '0);
    assign clr_en = we_q;

    assign bus.rs1       = bus.issue_rs1;
    assign bus.rs1_valid = bus.issue_valid & bus.issue_rs1_used;
    assign bus.rs2       = bus.issue_rs2;
    assign bus.rs2_valid = bus.issue_valid & bus.issue_rs2_used;

    assign req = {bus.wb1_valid, bus.wb0_valid};

    wb_rr_arbiter u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .advance (grant),
        .gnt     (gnt)
    );

    assign bus.wb0_ready = reset & gnt[0];
    assign bus.wb1_ready = reset & gnt[1];
    assign grant    = bus.wb0_ready | bus.wb1_ready;
    assign sel_rd   = bus.wb1_ready ? bus.wb1_rd : bus.wb0_rd;
    assign sel_data = bus.wb1_ready ? bus.wb1_data : bus.wb0_data;

    // Writes to x0 are accepted but never reach the port.
    always_ff @(posedge clk) begin
        if (!reset) begin
            we_q   <= 1'b0;
            rw_q   <= '0;
            wval_q <= '0;
        end else begin
            we_q <= grant & (sel_rd != '0);
            if (grant && sel_rd != '0) begin
                rw_q   <= sel_rd;
                wval_q <= sel_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            busy_q <= '0;
        end else begin
            for (int i = 1; i < NumRegs; i++) begin
                if (set_en && bus.issue_rd == reg_t'(i)) begin
                    busy_q[i] <= 1'b1;
                end else if (clr_en && rw_q == reg_t'(i)) begin
                    busy_q[i] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (set_en && !clr_en) begin
            cnt_d = cnt_q + CntW'(1);
        end else if (!set_en && clr_en) begin
            cnt_d = cnt_q - CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bus.rw          = rw_q;
    assign bus.we          = we_q;
    assign bus.wval        = wval_q;
    assign bus.outstanding = cnt_q;

`ifndef SYNTHESIS
    a_no_set_clr: assert property (
        @(posedge clk) disable iff (!reset)
        !(set_en && clr_en && bus.issue_rd == rw_q)
    );

    a_cnt_popcount: assert property (
        @(posedge clk) disable iff (!reset)
        32'(cnt_q) == 32'($countones(busy_q))
    );

    a_write_busy: assert property (
        @(posedge clk) disable iff (!reset)
        we_q |-> hit(busy, rw_q)
    );
`endif

endmodule

// File: doc/regfile_ctrl.md
Name: regfile_ctrl

Overview:
Scoreboard and write-port scheduler placed in front of the 2-read/1-write regfile (rvcpu::reg_t addresses, Width-bit data).
- Tracks which architectural registers have a write in flight.
- Stalls issue on RAW/WAW hazards.
- Arbitrates two writeback sources (wb0 = ALU, wb1 = LSU) onto the single registered write port.

Parameters:
Width, 32, data width of writeback values and of wval.
NumRegs, 32, number of architectural registers; x0 is hard-wired zero.

Ports:
clk  in  1  clock; all state updates on rising edge.
reset  in  1  synchronous, active-low reset.
issue_valid  in  1  decoder presents an instruction.
issue_ready  out  1  instruction accepted this cycle (fire = valid & ready).
issue_rs1  in  rvcpu::reg_t  source 1.
issue_rs1_used  in  1  source 1 is read.
issue_rs2  in  rvcpu::reg_t  source 2.
issue_rs2_used  in  1  source 2 is read.
issue_rd  in  rvcpu::reg_t  destination.
issue_rd_used  in  1  instruction writes rd.
rs1  out  rvcpu::reg_t  to regfile; equals issue_rs1.
rs1_valid  out  1  issue_valid & issue_rs1_used.
rs2  out  rvcpu::reg_t  to regfile; equals issue_rs2.
rs2_valid  out  1  issue_valid & issue_rs2_used.
wb0_valid  in  1  ALU writeback request.
wb0_ready  out  1  ALU request granted.
wb0_rd  in  rvcpu::reg_t  ALU destination.
wb0_data  in  Width  ALU result.
wb1_valid  in  1  LSU writeback request.
wb1_ready  out  1  LSU request granted.
wb1_rd  in  rvcpu::reg_t  LSU destination.
wb1_data  in  Width  LSU result.
rw  out  rvcpu::reg_t  regfile write address (registered).
we  out  1  regfile write enable (registered).
wval  out  Width  regfile write data (registered).
outstanding  out  $clog2(NumRegs)  count of busy bits.

Behaviour:
- State:
  - busy[NumRegs-1:1]; busy[0] is constant 0.
  - rr_last, 1 bit: the last granted writeback source.
  - Write-port registers rw, we, wval.
  - outstanding counter.
- Reset (reset==0 at an edge): busy=0, rr_last=1, we=0, rw=0, wval=0, outstanding=0.
  - While reset is low, issue_ready, wb0_ready and wb1_ready are forced to 0.
  - Reset mid-operation drops all in-flight state.
- Hazard check, combinational:
  - Stall if (rs1_used & busy[rs1]) | (rs2_used & busy[rs2]) | (rd_used & busy[rd]).
  - issue_ready = issue_valid & !stall. Ready is not asserted without valid.
  - There is no bypass. A register whose write is in the rf stage this cycle is still busy.
- Issue fire with rd_used & rd!=0: busy[rd] is set at the edge. rd==0 never sets busy.
- Arbitration, combinational, round-robin:
  - Only one valid: that source is granted.
  - Both valid: grant the source != rr_last.
  - rr_last updates to the granted source on any grant.
  - Grant is independent of busy and of issue.
  - A writeback whose rd==0 is granted and discarded: we stays 0 next cycle and no busy bit is touched.
- Write stage, one cycle latency:
  - Grant in cycle c gives we=1, rw=rd, wval=data in cycle c+1.
  - With no grant, we=0 in c+1; rw/wval hold.
  - The regfile commits at the end of c+1.
- Busy clear:
  - At the end of c+1 (we==1), busy[rw] is cleared.
  - An issue reading that register can fire in c+2 at the earliest.
- Simultaneous set and clear of the same index: cannot occur, because issue stalls on busy[rd]. An implementation must assert this (SVA, synthesis-off).
- outstanding: +1 on a set, −1 on a clear, net 0 when both happen in the same cycle.
  - Saturation is impossible (max NumRegs-1).
  - Must always equal popcount(busy); checked by assertion.
- A writeback to a non-busy register is still written. It is a protocol error by the execution units and is flagged by assertion only.

Decomposition:
- rvcpu package holds reg_t (existing) and a new wb_src_e enum {WB_ALU, WB_LSU} used for rr_last.
- One natural sub-module, wb_rr_arbiter:
  - 2-way round-robin arbiter.
  - Inputs: req[1:0], advance. Outputs: gnt[1:0]. Holds the rr_last flop.
- Scoreboard, write stage and counter stay in regfile_ctrl.

Test Plan:
- Reset low for 1 edge with wb0_valid=1 → wb0_ready=0. After release: we=0, outstanding=0, busy all 0.
- Issue rd=x1 (rd_used) in cycle 0 → outstanding=1. Next issue with rs1=x1 sees issue_ready=0. wb0 rd=1 data=123 granted in cycle 3 → we=1, rw=1, wval=123 in cycle 4. Stalled issue fires in cycle 5. Regfile reads 123 via rd1.
- Issue x2 and x3. wb0(rd=2, 456) and wb1(rd=3, 789) both valid in the same cycle with rr_last=1 → wb0 granted first and wb1 next cycle. Writes appear on consecutive cycles. outstanding goes 2→1→0.
- WAW: x5 busy and issue rd=5 → issue_ready=0 until the cycle after we=1 with rw=5.
- Issue with rd=x0 and rd_used=1 → issue_ready=1, outstanding unchanged. wb1 rd=0 → granted, we stays 0.
- Reset asserted while x4 busy and a grant pending in the write stage → next cycle we=0, outstanding=0. Issue reading x4 is accepted immediately.
